mult32_seq: RTL and testbench
=============================

Name: mult32_seq

Overview:
- Sequential unsigned shift-add multiplier for the ALU's multiply opcode.
- Sits in the execute stage next to the combinational bitwise units (xor32, and32, or32).
- Its low product word feeds the same ALU result mux that consumes xor32.out; the high word feeds the HI register.
- Handles one operation at a time under a start/busy/done handshake. Computes one bit per clock.

Parameters:
- WIDTH, 32, operand width in bits. Product width is 2*WIDTH. Iteration count is WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request a new multiply; sampled on rising edge.
- a  input  WIDTH  multiplicand; sampled only on an accepted start.
- b  input  WIDTH  multiplier; sampled only on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: product valid and newly updated.
- product  output  2*WIDTH  result register; holds its value until the next completion.

Behaviour:
- One clock; reset is synchronous and active-low (rst_n low at a rising edge of clk). All state changes on clk rising edge.
- Reset values: state=IDLE, busy=0, done=0, product=0, counter=0, internal registers=0.
- Reset mid-operation aborts the operation: no done pulse, product forced to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 → latch mcand<=a and acc<={WIDTH'b0, b}, count<=0, go to RUN. start=0 → stay in IDLE.
  - RUN, each edge:
    - sum = {1'b0, acc[2W-1:W]} + (acc[0] ? mcand : 0), computed at WIDTH+1 bits so the carry is preserved.
    - acc <= {sum, acc[W-1:1]} (logical right shift with the carry shifted in).
    - count <= count+1.
    - On the edge where count==WIDTH-1: product <= next acc value, done<=1, go to DONE.
  - DONE: lasts exactly one cycle, with done=1. The next edge clears done.
    - If start=1 on that edge, the new operation is accepted (back-to-back) and the state goes to RUN.
    - Otherwise the state goes to IDLE.
- Latency: start sampled at E0 → product valid and done=1 immediately after edge E(WIDTH), i.e. E32 for the default width. Throughput is one result per WIDTH+1 cycles.
- busy is 1 in the cycles after E0 through E(WIDTH); it is 0 in IDLE and DONE. busy is a registered output derived from the state.
- start while busy=1 is ignored: no restart, and a and b are not resampled.
- a and b may change freely after acceptance without affecting the result.
- product changes only at completion or reset. Intermediate acc values never appear on product.
- Arithmetic is unsigned. The full 2*WIDTH result is exact, with no overflow: max is (2^W-1)^2 < 2^(2W).
- The counter is log2(WIDTH)+1 bits wide and wraps to 0 on each new start.
- Simultaneous rst_n=0 and start=1: reset wins.

Test Plan:
- Basic: rst_n=0 for 2 cycles, then start with a=47, b=25.
  - Required: busy=1 for 32 cycles, done pulses once in the cycle after E32, product=64'd1175, busy=0 while done=1.
- Extremes:
  - a=32'hFFFFFFFF, b=32'hFFFFFFFF → product=64'hFFFFFFFE00000001.
  - a=0, b=32'h12345678 → product=0, done still after 32 cycles.
  - a=1, b=32'h80000000 → product=64'h0000000080000000.
- Busy protection: start a=3, b=5; at cycle 10 pulse start with a=7, b=9 and change a and b.
  - Required: exactly one done, product=15, no second done.
- Back-to-back: hold start=1 during the DONE cycle with a=6, b=7.
  - Required: first product=previous result; the new operation begins without passing through IDLE; second done 33 cycles after the first; product=42.
- Reset mid-op: start a=100, b=200; drive rst_n=0 at cycle 16 for one cycle.
  - Required: busy=0, product=0, no done pulse. A new start with a=2, b=3 afterwards yields product=6.
- Hold: after a completion, keep start=0 for 50 cycles.
  - Required: product stable at the last value, done=0, busy=0.

Source files
------------

// File: rtl/mult32_seq.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock, start/busy/done handshake.
// Low product word feeds the ALU result mux, high word feeds HI.
module mult32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    count_q;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic               last_iter;

  // Upper half accumulates; the carry is shifted back in so no product bit is lost.
  always_comb begin
    sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_next  = {sum, acc_q[WIDTH-1:1]};
    last_iter = (count_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, b};
            count_q <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_next;
          count_q <= count_q + CntW'(1);
          if (last_iter) begin
            product <= acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          done <= 1'b0;
          // Back-to-back accept skips IDLE entirely.
          if (start) begin
            mcand_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, b};
            count_q <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: stimulus pushes expected product and completion cycle,
// a forked monitor pops and compares on every done pulse.
module tb_mult32_seq;

  localparam int unsigned WIDTH = 32;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  mult32_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_run = 0;

  logic [2*WIDTH-1:0] exp_prod_q[$];
  int                 exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Drive one start pulse after a rising edge; optionally record the expected completion.
  task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic [2*WIDTH-1:0] exp, input bit push);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = va;
    b     = vb;
    if (push) begin
      exp_prod_q.push_back(exp);
      exp_cyc_q.push_back(cyc + 1 + WIDTH);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
    end
  endtask

  initial begin
    int base;
    int bad;
    logic [2*WIDTH-1:0] held;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          busy_run = 0;
        end else begin
          if (busy === 1'b1) busy_run++;
          if (done === 1'b1) begin
            done_cnt++;
            if (exp_prod_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: got product 0x%016h at cycle %0d expected no done",
                       product, cyc);
            end else begin
              check("product", product, exp_prod_q.pop_front());
              check("done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
              check("busy_low_at_done", {63'd0, busy}, 64'd0);
              check("busy_cycles", 64'(busy_run), 64'(WIDTH));
            end
            busy_run = 0;
          end
        end
      end
    join_none

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    rst_n = 1'b1;

    // Basic and extremes
    issue(32'd47, 32'd25, 64'd1175, 1'b1);
    wait_done(1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    wait_done(2);
    issue(32'd0, 32'h1234_5678, 64'd0, 1'b1);
    wait_done(3);
    issue(32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000, 1'b1);
    wait_done(4);

    // Busy protection: a second start mid-run is ignored, operands change freely
    issue(32'd3, 32'd5, 64'd15, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'hCAFE_F00D;
    wait_done(5);
    repeat (40) @(posedge clk);
    check("no_second_done", 64'(done_cnt), 64'd5);

    // Back-to-back: start held during the DONE cycle
    issue(32'd11, 32'd13, 64'd143, 1'b1);
    repeat (WIDTH) @(posedge clk);
    #1;
    check("b2b_done_cycle_seen", {63'd0, done}, 64'd1);
    start = 1'b1;
    a     = 32'd6;
    b     = 32'd7;
    exp_prod_q.push_back(64'd42);
    exp_cyc_q.push_back(cyc + 1 + WIDTH);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy_no_idle", {63'd0, busy}, 64'd1);
    wait_done(7);

    // Reset mid-operation aborts with no done
    base = done_cnt;
    issue(32'd100, 32'd200, 64'd0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    repeat (40) @(posedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(base));
    issue(32'd2, 32'd3, 64'd6, 1'b1);
    wait_done(base + 1);

    // Hold: product stable and outputs idle with start low
    held = 64'd6;
    bad  = 0;
    repeat (50) begin
      @(negedge clk);
      if (product !== held || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("hold_violations", 64'(bad), 64'd0);
    check("hold_product", product, held);
    check("scoreboard_empty", 64'(exp_prod_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
